// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B computed LSB-first, one bit per clock,
// through a single registered borrow stage. Result and borrow hold between operations.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_out;

   logic             w_ai;
   logic             w_bi;
   logic             w_d;
   logic             w_borrow_nx;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nx;

   // One full-subtractor cell shared across all bit positions.
   assign w_ai        = r_a_sh[0];
   assign w_bi        = r_b_sh[0];
   assign w_d         = w_ai ^ w_bi ^ r_borrow;
   assign w_borrow_nx = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res_nx    = {w_d, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_a_sh       <= '0;
         r_b_sh       <= '0;
         r_res        <= '0;
         r_borrow     <= 1'b0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_SHIFT: begin
               r_res    <= w_res_nx;
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_borrow <= w_borrow_nx;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  // Publish only on the final step so diff never shows partial sums.
                  r_state      <= S_DONE;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_diff       <= w_res_nx;
                  r_borrow_out <= w_borrow_nx;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request, giving back-to-back issue.
               if (start) begin
                  r_state  <= S_SHIFT;
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_res    <= '0;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8: stimulus pushes
// expectations on each accepted start, a negedge monitor pops them on done.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, start1;
   logic [3:0] a0, b0, diff0;
   logic [7:0] a1, b1, diff1;
   logic       busy0, done0, bo0;
   logic       busy1, done1, bo1;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .diff(diff0), .borrow_out(bo0)
   );

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   typedef struct packed {
      logic [7:0]  diff;
      logic        bo;
      logic [31:0] due;
   } exp_t;

   exp_t       q[2][$];
   logic [7:0] held_diff[2];
   logic       held_bo[2];
   int         busy_cnt[2];
   int         dones[2];
   bit         hand_valid[2];
   logic [7:0] hand_diff[2];
   logic       hand_bo[2];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic mon(input int k, input int w, input logic dn, input logic bs, input logic st,
                      input logic [7:0] df, input logic bo, input logic [7:0] av, input logic [7:0] bv);
      exp_t       e;
      logic [7:0] mask;
      logic [8:0] t;
      if (!rst_n) return;
      if (bs) begin
         busy_cnt[k]++;
         chk(df == held_diff[k], "diff_hold", df, held_diff[k]);
         chk(bo == held_bo[k], "borrow_hold", bo, held_bo[k]);
      end
      if (dn) begin
         if (q[k].size() == 0) begin
            chk(1'b0, "spurious_done", 1, 0);
         end else begin
            e = q[k].pop_front();
            dones[k]++;
            chk(df == e.diff, "diff", df, e.diff);
            chk(bo == e.bo, "borrow_out", bo, e.bo);
            chk(cyc == int'(e.due), "latency", cyc, e.due);
            chk(busy_cnt[k] == w, "busy_cycles", busy_cnt[k], w);
            held_diff[k] = e.diff;
            held_bo[k]   = e.bo;
         end
      end else if (q[k].size() != 0 && cyc > int'(q[k][0].due)) begin
         chk(1'b0, "done_timeout", cyc, q[k][0].due);
         void'(q[k].pop_front());
      end
      if (st && !bs) begin
         mask = (w == 4) ? 8'h0F : 8'hFF;
         t    = {1'b0, av} - {1'b0, bv};
         e.diff = hand_valid[k] ? hand_diff[k] : (t[7:0] & mask);
         e.bo   = hand_valid[k] ? hand_bo[k] : (av < bv);
         // Acceptance edge is the next posedge; done is seen WIDTH edges later.
         e.due  = 32'(cyc + 1 + w);
         busy_cnt[k] = 0;
         q[k].push_back(e);
      end
   endtask

   always @(negedge clk) begin
      mon(0, 4, done0, busy0, start0, {4'b0, diff0}, bo0, {4'b0, a0}, {4'b0, b0});
      mon(1, 8, done1, busy1, start1, diff1, bo1, a1, b1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int k);
      for (int i = 0; i < 64 && q[k].size() != 0; i++) tick();
      tick();
   endtask

   task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] ed, input logic eb, input bit hand);
      a0 = av; b0 = bv; start0 = 1'b1;
      hand_valid[0] = hand; hand_diff[0] = {4'b0, ed}; hand_bo[0] = eb;
      tick();
      start0 = 1'b0; hand_valid[0] = 1'b0;
      drain(0);
   endtask

   task automatic op8(input logic [7:0] av, input logic [7:0] bv);
      a1 = av; b1 = bv; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      drain(1);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0;
      start0 = 1'b0; a0 = '0; b0 = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      for (int k = 0; k < 2; k++) begin
         held_diff[k] = '0; held_bo[k] = 1'b0; busy_cnt[k] = 0; dones[k] = 0;
         hand_valid[k] = 1'b0; hand_diff[k] = '0; hand_bo[k] = 1'b0;
      end
      tick();
      tick();
      chk(busy0 == 1'b0, "rst_busy", busy0, 0);
      chk(done0 == 1'b0, "rst_done", done0, 0);
      chk(diff0 == 4'h0, "rst_diff", diff0, 0);
      chk(bo0 == 1'b0, "rst_borrow", bo0, 0);
      chk(busy1 == 1'b0 && done1 == 1'b0 && diff1 == 8'h0 && bo1 == 1'b0, "rst_w8", {busy1, done1, bo1}, 0);
      rst_n = 1'b1;
      tick();

      op4(4'd9,  4'd3,  4'h6, 1'b0, 1'b1);
      op4(4'd3,  4'd9,  4'hA, 1'b1, 1'b1);
      op4(4'd0,  4'd1,  4'hF, 1'b1, 1'b1);
      op4(4'd15, 4'd15, 4'h0, 1'b0, 1'b1);
      op4(4'd0,  4'd0,  4'h0, 1'b0, 1'b1);

      // Start held high: a new operation is accepted in every DONE cycle.
      d0 = dones[0];
      a0 = 4'd9; b0 = 4'd3; start0 = 1'b1;
      hand_valid[0] = 1'b1; hand_diff[0] = 8'h06; hand_bo[0] = 1'b0;
      for (int i = 0; i < 60 && dones[0] < d0 + 4; i++) tick();
      start0 = 1'b0;
      chk(dones[0] - d0 >= 4, "b2b_count", dones[0] - d0, 4);
      drain(0);
      hand_valid[0] = 1'b0;

      // Operand changes after capture are ignored.
      a0 = 4'd9; b0 = 4'd3; start0 = 1'b1;
      hand_valid[0] = 1'b1; hand_diff[0] = 8'h06; hand_bo[0] = 1'b0;
      tick();
      start0 = 1'b0; hand_valid[0] = 1'b0;
      tick();
      a0 = 4'd1; b0 = 4'd14;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      drain(0);

      // Asynchronous reset two cycles into SHIFT aborts the operation.
      a0 = 4'd9; b0 = 4'd3; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk(busy0 == 1'b0, "abort_busy", busy0, 0);
      chk(done0 == 1'b0, "abort_done", done0, 0);
      chk(diff0 == 4'h0, "abort_diff", diff0, 0);
      chk(bo0 == 1'b0, "abort_borrow", bo0, 0);
      q[0].delete();
      held_diff[0] = '0; held_bo[0] = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      op4(4'd12, 4'd5, 4'h7, 1'b0, 1'b1);

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            op4(4'(x), 4'(y), 4'h0, 1'b0, 1'b0);

      op8(8'h00, 8'h01);
      op8(8'hFF, 8'hFF);
      for (int i = 0; i < 1000; i++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      chk(q[0].size() == 0 && q[1].size() == 0, "queue_empty", q[0].size() + q[1].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
